// File: rtl/br_update_queue.sv
// Branch-update queue: accepts up to two committed branches per cycle and drains one per
// cycle to the predictor update port. Define BR_UPD_BYPASS_EN for zero-latency idle bypass.
module br_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             commit0_valid_i,
  input  logic [31:0]      commit0_pc_i,
  input  logic             commit0_taken_i,
  input  logic             commit1_valid_i,
  input  logic [31:0]      commit1_pc_i,
  input  logic             commit1_taken_i,
  output logic             commit_ready_o,
  output logic             upd_valid_o,
  output logic [31:0]      upd_pc_o,
  output logic             upd_taken_o,
  input  logic             upd_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, wr_ptr_inc;
  logic [CNT_W-1:0] count_q, count_d, free_c;
  logic             overflow_q;
  logic [32:0]      mem_q [DEPTH];
  logic             head_valid, deq, commit_any;
  logic             keep0, keep1, wr0_en, wr1_en;
  logic [32:0]      wr0_data, wr1_data;
  logic [1:0]       enq_n;

  // Ready is derived from registered occupancy only; held low while reset is asserted.
  assign free_c         = CNT_W'(DEPTH) - count_q;
  assign commit_ready_o = rst_ni & (free_c >= CNT_W'(2));
  assign head_valid     = (count_q != '0);
  assign deq            = head_valid & upd_ready_i;
  assign commit_any     = commit0_valid_i | commit1_valid_i;

`ifdef BR_UPD_BYPASS_EN
  logic        byp, byp0, byp1;
  logic [32:0] byp_data;

  // On an idle queue the oldest valid commit goes straight to the predictor and is not stored.
  assign byp      = ~head_valid & commit_ready_o & upd_ready_i & commit_any;
  assign byp0     = byp & commit0_valid_i;
  assign byp1     = byp & ~commit0_valid_i;
  assign byp_data = commit0_valid_i ? {commit0_taken_i, commit0_pc_i}
                                    : {commit1_taken_i, commit1_pc_i};
  assign keep0    = commit_ready_o & commit0_valid_i & ~byp0;
  assign keep1    = commit_ready_o & commit1_valid_i & ~byp1;
  assign upd_valid_o = head_valid | byp;

  always_comb begin
    {upd_taken_o, upd_pc_o} = '0;
    if (head_valid)
      {upd_taken_o, upd_pc_o} = mem_q[rd_ptr_q];
    else if (byp)
      {upd_taken_o, upd_pc_o} = byp_data;
  end
`else
  assign keep0       = commit_ready_o & commit0_valid_i;
  assign keep1       = commit_ready_o & commit1_valid_i;
  assign upd_valid_o = head_valid;
  assign {upd_taken_o, upd_pc_o} = head_valid ? mem_q[rd_ptr_q] : '0;
`endif

  // Compact the surviving commits so program order lands in consecutive slots.
  assign wr0_en     = keep0 | keep1;
  assign wr0_data   = keep0 ? {commit0_taken_i, commit0_pc_i} : {commit1_taken_i, commit1_pc_i};
  assign wr1_en     = keep0 & keep1;
  assign wr1_data   = {commit1_taken_i, commit1_pc_i};
  assign enq_n      = {1'b0, keep0} + {1'b0, keep1};
  assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
  assign count_d    = count_q + CNT_W'(enq_n) - CNT_W'(deq);

  always_ff @(posedge clk_i) begin
    if (wr0_en) mem_q[wr_ptr_q]   <= wr0_data;
    if (wr1_en) mem_q[wr_ptr_inc] <= wr1_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_q + PTR_W'(deq);
      wr_ptr_q   <= wr_ptr_q + PTR_W'(enq_n);
      count_q    <= count_d;
      overflow_q <= overflow_q | (commit_any & ~commit_ready_o);
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
